// File: rtl/uart_frame_receiver.sv
// UART receiver: 8-bit LSB-first bytes with optional parity, assembled into a
// NUM_BYTES-wide command word that updates atomically with a one-cycle strobe.
module uart_frame_receiver #(
    parameter int CLKS_PER_BIT      = 2815,
    parameter int NUM_BYTES         = 17,
    parameter int PARITY_MODE       = 0,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           rx_i,
    output logic [8*NUM_BYTES-1:0]         written_values_o,
    output logic                           frame_valid_o,
    output logic [7:0]                     byte_o,
    output logic                           byte_valid_o,
    output logic                           framing_error_o,
    output logic                           parity_error_o,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_index_o
);
    localparam int IDX_W      = $clog2(NUM_BYTES + 1);
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int IDLE_LIMIT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);
    localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v == IDLE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        logic x;
        x = ^{d, p};
        if (PARITY_MODE == 1)
            return ~x;
        else if (PARITY_MODE == 2)
            return x;
        else
            return 1'b1;
    endfunction

    logic                   rx_sync_p0;
    logic                   rx_sync_p1;
    logic                   rx_s;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             data_sr;
    logic                   parity_bit;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [IDX_W-1:0]       byte_index;
    logic [8*NUM_BYTES-1:0] staging;
    logic [8*NUM_BYTES-1:0] frame_word;

    logic                   cnt_clr;
    logic                   data_tick;
    logic                   parity_tick;
    logic                   stop_tick;
    logic                   par_ok;
    logic                   accept;
    logic                   frame_done;
    logic                   timeout_hit;

    // stage p0/p1: two-flop synchroniser on the asynchronous line
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_i;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_s = rx_sync_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        data_tick   = 1'b0;
        parity_tick = 1'b0;
        stop_tick   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s)
                    state_nxt = S_START;
            end
            S_START: begin
                // a line that is high again at mid-start was a glitch
                if (cnt == HALF_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr   = 1'b1;
                    data_tick = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr     = 1'b1;
                    parity_tick = 1'b1;
                    state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr   = 1'b1;
                    stop_tick = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            data_sr    <= '0;
            parity_bit <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state != S_DATA)
                bit_cnt <= '0;
            else if (data_tick)
                bit_cnt <= bit_cnt + 1'b1;
            if (data_tick)
                data_sr[bit_cnt] <= rx_s;
            if (parity_tick)
                parity_bit <= rx_s;
            if (state == S_IDLE && rx_s)
                idle_cnt <= sat_inc(idle_cnt);
            else
                idle_cnt <= '0;
        end
    end

    assign par_ok      = parity_ok(data_sr, parity_bit);
    assign accept      = stop_tick & rx_s & par_ok;
    assign frame_done  = accept && (byte_index == LAST_SLOT);
    assign timeout_hit = (idle_cnt == IDLE_MAX) && (byte_index != '0);

    // the final byte bypasses staging so the whole word lands in one cycle
    always_comb begin
        frame_word = staging;
        frame_word[8*NUM_BYTES-1 -: 8] = data_sr;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte_index       <= '0;
            staging          <= '0;
            written_values_o <= '0;
            frame_valid_o    <= 1'b0;
            byte_o           <= '0;
            byte_valid_o     <= 1'b0;
            framing_error_o  <= 1'b0;
            parity_error_o   <= 1'b0;
        end else begin
            byte_valid_o    <= accept;
            frame_valid_o   <= frame_done;
            framing_error_o <= stop_tick & ~rx_s;
            parity_error_o  <= stop_tick & ~par_ok;
            if (accept)
                byte_o <= data_sr;
            if (stop_tick) begin
                if (!accept || frame_done)
                    byte_index <= '0;
                else
                    byte_index <= byte_index + 1'b1;
            end else if (timeout_hit) begin
                byte_index <= '0;
            end
            if (accept) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (byte_index == IDX_W'(k))
                        staging[8*k +: 8] <= data_sr;
                end
            end
            if (frame_done)
                written_values_o <= frame_word;
        end
    end

    assign byte_index_o = byte_index;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: directed scenarios plus randomized bytes on a
// no-parity and an odd-parity instance, scored against a frame-level model.
module tb_uart_frame_receiver;
    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int NB = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic [31:0] wv0, wv1;
    logic        fv0, fv1, bv0, bv1, fe0, fe1, pe0, pe1;
    logic [7:0]  bo0, bo1;
    logic [2:0]  bi0, bi1;

    uart_frame_receiver #(
        .CLKS_PER_BIT(C), .NUM_BYTES(NB), .PARITY_MODE(0), .IDLE_TIMEOUT_BITS(TO)
    ) dut0 (
        .clk_i(clk), .reset_i(rst), .rx_i(rx0),
        .written_values_o(wv0), .frame_valid_o(fv0), .byte_o(bo0),
        .byte_valid_o(bv0), .framing_error_o(fe0), .parity_error_o(pe0),
        .byte_index_o(bi0)
    );

    uart_frame_receiver #(
        .CLKS_PER_BIT(C), .NUM_BYTES(NB), .PARITY_MODE(2), .IDLE_TIMEOUT_BITS(TO)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .rx_i(rx1),
        .written_values_o(wv1), .frame_valid_o(fv1), .byte_o(bo1),
        .byte_valid_o(bv1), .framing_error_o(fe1), .parity_error_o(pe1),
        .byte_index_o(bi1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        bv;
        logic        fe;
        logic        pe;
        logic        fv;
        logic [7:0]  b;
        logic [31:0] word;
        int          idx;
    } ev_t;

    ev_t         q0[$];
    ev_t         q1[$];
    ev_t         ev0, ev1;
    logic [7:0]  part_m [2][NB];
    int          part_n [2];
    logic [31:0] word_m [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fv_cnt0 = 0, bv_cnt0 = 0, fe_cnt0 = 0, fv_cnt1 = 0, pe_cnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic match(input string pfx, input ev_t e, input logic bv, input logic fe,
                         input logic pe, input logic fv, input logic [7:0] bo,
                         input logic [31:0] wv, input logic [2:0] bi);
        chk({pfx, " byte_valid"}, bv, e.bv);
        chk({pfx, " framing_error"}, fe, e.fe);
        chk({pfx, " parity_error"}, pe, e.pe);
        chk({pfx, " frame_valid"}, fv, e.fv);
        if (e.bv)
            chk({pfx, " byte_o"}, bo, e.b);
        chk({pfx, " written_values"}, wv, e.word);
        chk({pfx, " byte_index"}, bi, e.idx);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (fv0) fv_cnt0++;
            if (bv0) bv_cnt0++;
            if (fe0) fe_cnt0++;
            if (q0.size() != 0 && q0[0].cyc == cyc) begin
                ev0 = q0.pop_front();
                match("d0", ev0, bv0, fe0, pe0, fv0, bo0, wv0, bi0);
            end else if ({bv0, fe0, pe0, fv0} != 4'b0) begin
                chk("d0 unexpected pulse", {bv0, fe0, pe0, fv0}, 4'b0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (fv1) fv_cnt1++;
            if (pe1) pe_cnt1++;
            if (q1.size() != 0 && q1[0].cyc == cyc) begin
                ev1 = q1.pop_front();
                match("d1", ev1, bv1, fe1, pe1, fv1, bo1, wv1, bi1);
            end else if ({bv1, fe1, pe1, fv1} != 4'b0) begin
                chk("d1 unexpected pulse", {bv1, fe1, pe1, fv1}, 4'b0);
            end
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    // Called on a negedge; the start bit is sampled at the next posedge (T0).
    task automatic send_byte(input int d, input logic [7:0] b, input logic stop, input logic pbit);
        ev_t e;
        int  p;
        p      = (d == 1) ? 1 : 0;
        e.cyc  = cyc + 1 + 2 + H + (9 + p) * C;
        e.fe   = !stop;
        e.pe   = (p == 1) && ((^b ^ pbit) == 1'b0);
        e.bv   = stop && !e.pe;
        e.fv   = 1'b0;
        e.b    = b;
        if (e.bv) begin
            part_m[d][part_n[d]] = b;
            part_n[d]++;
            if (part_n[d] == NB) begin
                for (int k = 0; k < NB; k++)
                    word_m[d][8*k +: 8] = part_m[d][k];
                part_n[d] = 0;
                e.fv = 1'b1;
            end
        end else begin
            part_n[d] = 0;
        end
        e.word = word_m[d];
        e.idx  = part_n[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);

        set_rx(d, 1'b0);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, b[i]);
            repeat (C) @(negedge clk);
        end
        if (p == 1) begin
            set_rx(d, pbit);
            repeat (C) @(negedge clk);
        end
        set_rx(d, stop);
        repeat (C) @(negedge clk);
        set_rx(d, 1'b1);
    endtask

    task automatic send_ok(input int d, input logic [7:0] b);
        send_byte(d, b, 1'b1, ~(^b));
    endtask

    task automatic idle_bits(input int d, input int n);
        repeat (n * C) @(negedge clk);
        if (n >= TO)
            part_n[d] = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20 * C) begin
            @(negedge clk);
            k++;
        end
        chk("events outstanding", q0.size() + q1.size(), 0);
    endtask

    logic [7:0] bb [8];
    int         cur_d, gap, base_fv, base_bv, base_fe, base_pe;
    logic [7:0] rb;
    logic       rs, rp;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        part_n = '{0, 0};
        word_m = '{32'h0, 32'h0};
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset written_values", wv0, 32'h0);
        chk("reset byte_o", bo0, 8'h0);
        chk("reset byte_index", bi0, 3'd0);
        chk("reset pulses", {bv0, fe0, pe0, fv0}, 4'b0);
        chk("reset d1 written_values", wv1, 32'h0);
        repeat (2 * C) @(negedge clk);

        // 1: partial frame, reset in the middle of a byte, then a clean frame
        send_ok(0, 8'h5C);
        send_ok(0, 8'h3A);
        drain();
        chk("pre-reset byte_index", bi0, 3'd2);
        rx0 = 1'b0;
        repeat (3 * C) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid-byte reset byte_o", bo0, 8'h0);
        chk("mid-byte reset byte_index", bi0, 3'd0);
        rx0 = 1'b1;
        rst = 1'b0;
        part_n = '{0, 0};
        word_m = '{32'h0, 32'h0};
        repeat (2 * C) @(negedge clk);
        base_fv = fv_cnt0;
        base_bv = bv_cnt0;
        send_ok(0, 8'h11);
        send_ok(0, 8'h22);
        send_ok(0, 8'h33);
        send_ok(0, 8'h44);
        drain();
        chk("frame1 word", wv0, 32'h44332211);
        chk("frame1 frame_valid count", fv_cnt0 - base_fv, 1);
        chk("frame1 byte_valid count", bv_cnt0 - base_bv, 4);

        // 2: false start glitch, then a frame
        base_bv = bv_cnt0;
        rx0 = 1'b0;
        repeat (5) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("false start byte_valid count", bv_cnt0 - base_bv, 0);
        send_ok(0, 8'hA5);
        send_ok(0, 8'h5A);
        send_ok(0, 8'hFF);
        send_ok(0, 8'h00);
        drain();
        chk("frame2 word", wv0, 32'h00FF5AA5);

        // 3: framing error on the third byte drops the partial frame
        base_fe = fe_cnt0;
        send_ok(0, 8'h01);
        send_ok(0, 8'h02);
        send_byte(0, 8'h03, 1'b0, 1'b0);
        idle_bits(0, 2);
        drain();
        chk("framing error count", fe_cnt0 - base_fe, 1);
        chk("framing error byte_index", bi0, 3'd0);
        chk("framing error word held", wv0, 32'h00FF5AA5);
        send_ok(0, 8'h10);
        send_ok(0, 8'h20);
        send_ok(0, 8'h30);
        send_ok(0, 8'h40);
        drain();
        chk("frame3 word", wv0, 32'h40302010);

        // 4: partial frame abandoned by idle timeout
        send_ok(0, 8'h61);
        send_ok(0, 8'h62);
        drain();
        chk("partial byte_index", bi0, 3'd2);
        idle_bits(0, 21);
        chk("timeout byte_index", bi0, 3'd0);
        send_ok(0, 8'hDE);
        send_ok(0, 8'hAD);
        send_ok(0, 8'hBE);
        send_ok(0, 8'hEF);
        drain();
        chk("frame4 word", wv0, 32'hEFBEADDE);

        // 5: odd parity instance
        base_pe = pe_cnt1;
        send_byte(1, 8'h01, 1'b1, 1'b0);
        drain();
        chk("odd parity accepted index", bi1, 3'd1);
        chk("odd parity accepted byte_o", bo1, 8'h01);
        send_byte(1, 8'h01, 1'b1, 1'b1);
        drain();
        chk("parity error count", pe_cnt1 - base_pe, 1);
        chk("parity error byte_index", bi1, 3'd0);
        chk("parity error word held", wv1, 32'h0);
        send_ok(1, 8'hC3);
        send_ok(1, 8'h00);
        send_ok(1, 8'h7E);
        send_ok(1, 8'h81);
        drain();
        chk("odd parity frame word", wv1, 32'h817E00C3);

        // 6: back-to-back bytes with no idle gap, two frames
        bb = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
        base_fv = fv_cnt0;
        for (int i = 0; i < 8; i++)
            send_ok(0, bb[i]);
        drain();
        chk("back-to-back frame count", fv_cnt0 - base_fv, 2);
        chk("back-to-back last word", wv0, 32'h78695A4B);

        // randomized bursts; both lines are idle well past the timeout at each switch
        cur_d = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || $urandom_range(0, 4) == 0) begin
                idle_bits(cur_d, TO + 5);
                part_n = '{0, 0};
                cur_d = int'($urandom_range(0, 1));
            end
            rb = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            rp = ~(^rb);
            if ($urandom_range(0, 7) == 0)
                rp = ~rp;
            send_byte(cur_d, rb, rs, rp);
            gap = rs ? int'($urandom_range(0, 3)) : 2 + int'($urandom_range(0, 2));
            idle_bits(cur_d, gap);
        end
        drain();
        chk("random d0 final word", wv0, word_m[0]);
        chk("random d1 final word", wv1, word_m[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
